task_slave_shell: RTL and testbench
===================================

# task_slave_shell

Task-side endpoint of the task manager's `task_in_interface` / `task_out_interface` pair. It sits between one task slot of the task manager and that task's compute core. The shell:
- requests and buffers the incoming test-vector bytes;
- starts the core and waits for it to finish;
- streams the core's answer words back to the manager with a ready handshake and a last flag.

Every task instance reuses it, so the compute cores never handle manager protocol timing.

## Interface
Parameters:
- `TASK_DIN_WIDTH`, 8: width of an input byte.
- `TASK_DOUT_WIDTH`, 32: width of an answer word.
- `IN_BYTES`, 64: input buffer depth in bytes. Maximum 4096.
- `OUT_WORDS`, 16: number of answer words returned per run. Minimum 1.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `task_data_request`  out  1  the shell can accept input bytes.
- `task_data_valid`  in  1  `task_data` is valid this cycle.
- `task_data`  in  TASK_DIN_WIDTH  input byte.
- `task_data_last`  in  1  final input byte of the vector.
- `task_answer_ready`  out  1  `task_answer_data` holds a valid word.
- `task_answer_data`  out  TASK_DOUT_WIDTH  answer word.
- `task_answer_data_last`  out  1  final answer word.
- `task_manager_ready`  in  1  the manager accepts the presented word.
- `core_start`  out  1  one-cycle run pulse to the core.
- `core_done`  in  1  one-cycle completion pulse from the core.
- `core_in_count`  out  $clog2(IN_BYTES+1)  number of bytes received.
- `core_in_rd_addr`  in  $clog2(IN_BYTES)  core read address into the input buffer.
- `core_in_rd_data`  out  TASK_DIN_WIDTH  input buffer read data, 1-cycle latency.
- `core_out_wr_en`  in  1  core write strobe into the output buffer.
- `core_out_wr_addr`  in  $clog2(OUT_WORDS)  core write address.
- `core_out_wr_data`  in  TASK_DOUT_WIDTH  core write data.
- `err_overflow`  out  1  sticky flag: an input byte was dropped.

## Operation
State machine, reset state RECV:
- **RECV.** `task_data_request`=1.
  - Each cycle with `task_data_valid`=1 and `in_cnt` < IN_BYTES: write the byte at `in_cnt`, then `in_cnt`++.
  - Exit to RUN when either:
    - `task_data_last` is accepted (the byte is stored, except when the buffer is already full), or
    - `in_cnt` reaches IN_BYTES.
- **RUN.**
  - `core_start` pulses in the first RUN cycle.
  - `core_in_count` holds the final `in_cnt`.
  - `core_done` moves the machine to FETCH.
- **FETCH.** Read the output buffer at `out_idx` (one cycle), then go to PRESENT.
- **PRESENT.**
  - `task_answer_ready`=1; `task_answer_data` = the word read.
  - `task_answer_data_last` = (`out_idx` == OUT_WORDS-1).
  - On `task_manager_ready`=1:
    - not the last word: `out_idx`++, go to FETCH;
    - last word: clear `in_cnt` and `out_idx`, go to RECV.

Drop and ignore rules:
- `task_data_valid` while in RUN, FETCH or PRESENT, or while the buffer is full: the byte is dropped and `err_overflow` is set. Only reset clears `err_overflow`.
- `core_done` outside RUN: ignored.
- `core_out_wr_en` is honoured in any state.
- `core_in_rd_addr` ≥ `in_cnt` returns stale buffer contents; this is not an error.
- Counter widths are `$clog2(IN_BYTES+1)` and `$clog2(OUT_WORDS)`. Neither counter wraps.

## Timing
- Reset values (all outputs 0, state RECV):
  - `task_data_request`=0, `task_answer_ready`=0, `task_answer_data`=0, `task_answer_data_last`=0;
  - `core_start`=0, `core_in_rd_data`=0, `core_in_count`=0, `err_overflow`=0.
- All outputs are registered.
- `task_data_request` rises the cycle after entering RECV. It falls the cycle after the exit condition.
- A byte sampled at edge N is readable by the core from edge N+1.
- `core_start` is high exactly one cycle: the first cycle after the RECV→RUN edge.
- First answer word is presented 2 cycles after `core_done` is sampled. Maximum throughput is 1 word per 2 cycles.
- `task_answer_data` and `task_answer_data_last` stay stable while `task_answer_ready`=1 and `task_manager_ready`=0.
- `task_data_last` and `task_data_valid` in the same cycle as IN_BYTES is reached: the byte is stored and RUN is entered once.
- A core write and a FETCH read to the same address in the same cycle return the old data.
- Reset mid-operation: the state machine, counters and flags return to their reset values. Buffer contents are not cleared.

## Configuration
- `TASK_SLAVE_LOOPBACK_EN` defined:
  - RUN does not pulse `core_start`. The shell packs input bytes into the output buffer itself: word k = bytes 4k..4k+3, little-endian, bytes at or beyond `in_cnt` zero.
  - Packing takes one cycle per word, OUT_WORDS cycles total, then the machine goes to FETCH.
  - `core_out_wr_en` and `core_done` are ignored.
- Not defined: core path as described in Operation.

## Structure
- `tasks_parameters` package holds:
  - the per-task IN_BYTES / OUT_WORDS values (existing TV_IN_BYTES / TV_OUT_NUM_TRANSACTIONS);
  - the `task_slave_state_e` enum (RECV, RUN, FETCH, PRESENT).
- Sub-module `task_slave_ram`: simple dual-port RAM, one write port and one read port with 1-cycle registered read. It is instantiated twice: input bytes and output words.

## Test plan
- Send 10 bytes 0x01..0x0A, last on 0x0A, IN_BYTES=64 -> `core_start` pulses once; `core_in_count`=10; `core_in_rd_addr`=3 returns 0x04.
- Core writes words 0xA0+i for i=0..15, then `core_done` -> 16 handshakes, data 0xA0..0xAF in order; `task_answer_data_last` only on 0xAF; `task_data_request` back to 1 afterwards.
- Hold `task_manager_ready`=0 for 5 cycles on word 3 -> data and ready stable for all 5 cycles; word 4 follows only after acceptance.
- Send 66 bytes without last, IN_BYTES=64 -> RUN after byte 64; `core_in_count`=64; `err_overflow`=1 after byte 65.
- Assert `i_rst` during PRESENT word 7 -> all outputs 0 next cycle; `task_data_request`=1 one cycle after reset release.
- Loopback build: send bytes 0x11,0x22,0x33,0x44,0x55 (last) -> word0=0x44332211, word1=0x00000055, words 2..15=0, `core_start` never asserted.

Source files
------------

// File: rtl/task_slave_shell_pkg.sv
// tasks_parameters: per-task buffer sizes and the task shell state encoding
package tasks_parameters;
   localparam int TV_IN_BYTES = 64;
   localparam int TV_OUT_NUM_TRANSACTIONS = 16;
   typedef enum logic [1:0] {RECV, RUN, FETCH, PRESENT} task_slave_state_e;
endpackage

// File: rtl/task_slave_shell_ram.sv
// task_slave_ram: simple dual-port RAM, registered read; read-during-write returns old data
module task_slave_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;
   always_ff @(posedge clk)
      if (rst) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/task_slave_shell.sv
// task_slave_shell: buffers task input bytes, runs the core, streams answer words back.
// Define TASK_SLAVE_LOOPBACK_EN to pack input bytes into the answer words instead of using the core.
module task_slave_shell
   import tasks_parameters::*;
#(
   parameter int TASK_DIN_WIDTH = 8,
   parameter int TASK_DOUT_WIDTH = 32,
   parameter int IN_BYTES = TV_IN_BYTES,
   parameter int OUT_WORDS = TV_OUT_NUM_TRANSACTIONS
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   output logic                           task_data_request,
   input  logic                           task_data_valid,
   input  logic [TASK_DIN_WIDTH-1:0]      task_data,
   input  logic                           task_data_last,
   output logic                           task_answer_ready,
   output logic [TASK_DOUT_WIDTH-1:0]     task_answer_data,
   output logic                           task_answer_data_last,
   input  logic                           task_manager_ready,
   output logic                           core_start,
   input  logic                           core_done,
   output logic [$clog2(IN_BYTES+1)-1:0]  core_in_count,
   input  logic [$clog2(IN_BYTES)-1:0]    core_in_rd_addr,
   output logic [TASK_DIN_WIDTH-1:0]      core_in_rd_data,
   input  logic                           core_out_wr_en,
   input  logic [$clog2(OUT_WORDS)-1:0]   core_out_wr_addr,
   input  logic [TASK_DOUT_WIDTH-1:0]     core_out_wr_data,
   output logic                           err_overflow
);
   localparam int CW = $clog2(IN_BYTES+1);
   localparam int AW = $clog2(IN_BYTES);
   localparam int OW = $clog2(OUT_WORDS);
   task_slave_state_e state, state_nx;
   logic [CW-1:0] in_cnt;
   logic [OW-1:0] out_idx;
   logic take, exit_recv, present_last, run_done, start_en, pack_step, adv;
   logic ow_en;
   logic [OW-1:0] ow_addr;
   logic [TASK_DOUT_WIDTH-1:0] ow_data;
   assign take = state == RECV && task_data_valid && in_cnt < CW'(IN_BYTES);
   assign exit_recv = state == RECV && (in_cnt == CW'(IN_BYTES) ||
                      (task_data_valid && (task_data_last || in_cnt == CW'(IN_BYTES-1))));
   assign present_last = out_idx == OW'(OUT_WORDS-1);
   assign adv = (state == PRESENT && task_manager_ready) || pack_step;
   assign core_in_count = in_cnt;
`ifdef TASK_SLAVE_LOOPBACK_EN
   localparam int LW = $clog2(TASK_DOUT_WIDTH/TASK_DIN_WIDTH);
   logic [TASK_DOUT_WIDTH-1:0] acc, packed_word;
   logic [LW-1:0] lane;
   logic unused;
   assign unused = ^{core_done, core_out_wr_en, core_out_wr_addr, core_out_wr_data};
   assign lane = in_cnt[LW-1:0];
   // each stored byte rewrites its word with the lanes gathered so far; later lanes stay zero
   assign packed_word = (lane == '0 ? '0 : acc) | (TASK_DOUT_WIDTH'(task_data) << (TASK_DIN_WIDTH * lane));
   always_ff @(posedge i_clk)
      if (take) acc <= packed_word;
   assign ow_en = (take && (32'(in_cnt) >> LW) < OUT_WORDS) ||
                  (state == RUN && (32'(out_idx) << LW) >= 32'(in_cnt));
   assign ow_addr = state == RUN ? out_idx : OW'(in_cnt >> LW);
   assign ow_data = state == RUN ? '0 : packed_word;
   assign run_done = present_last;
   assign start_en = 1'b0;
   assign pack_step = state == RUN;
`else
   assign ow_en = core_out_wr_en;
   assign ow_addr = core_out_wr_addr;
   assign ow_data = core_out_wr_data;
   assign run_done = core_done;
   assign start_en = 1'b1;
   assign pack_step = 1'b0;
`endif
   task_slave_ram #(.WIDTH(TASK_DIN_WIDTH), .DEPTH(IN_BYTES), .AW(AW)) in_ram (
      .clk(i_clk), .rst(i_rst), .wr_en(take), .wr_addr(in_cnt[AW-1:0]), .wr_data(task_data),
      .rd_en(1'b1), .rd_addr(core_in_rd_addr), .rd_data(core_in_rd_data)
   );
   task_slave_ram #(.WIDTH(TASK_DOUT_WIDTH), .DEPTH(OUT_WORDS), .AW(OW)) out_ram (
      .clk(i_clk), .rst(i_rst), .wr_en(ow_en), .wr_addr(ow_addr), .wr_data(ow_data),
      .rd_en(state == FETCH), .rd_addr(out_idx), .rd_data(task_answer_data)
   );
   always_comb begin
      state_nx = state;
      case (state)
         RECV:    state_nx = exit_recv ? RUN : RECV;
         RUN:     state_nx = run_done ? FETCH : RUN;
         FETCH:   state_nx = PRESENT;
         PRESENT: state_nx = !task_manager_ready ? PRESENT : present_last ? RECV : FETCH;
         default: state_nx = RECV;
      endcase
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state <= RECV;
         in_cnt <= '0;
         out_idx <= '0;
         task_data_request <= 1'b0;
         task_answer_ready <= 1'b0;
         task_answer_data_last <= 1'b0;
         core_start <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == PRESENT && task_manager_ready && present_last) in_cnt <= '0;
         else if (take) in_cnt <= in_cnt + 1'b1;
         if (adv) out_idx <= present_last ? '0 : out_idx + 1'b1;
         task_data_request <= state == RECV && !exit_recv;
         task_answer_ready <= state_nx == PRESENT;
         task_answer_data_last <= state_nx == PRESENT && present_last;
         core_start <= start_en && exit_recv;
         err_overflow <= err_overflow | (task_data_valid && !take);
      end
endmodule

// File: tb/tb_task_slave_shell.sv
// tb_task_slave_shell: randomized and directed runs of the task shell against a byte/word model
module tb_task_slave_shell;
   import tasks_parameters::*;
   localparam int IB = 64;
   localparam int OWN = 16;
`ifdef TASK_SLAVE_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif
   logic i_clk = 1'b0, i_rst = 1'b1;
   logic task_data_request, task_data_valid = 0, task_data_last = 0;
   logic [7:0] task_data = 0;
   logic task_answer_ready, task_answer_data_last, task_manager_ready = 0;
   logic [31:0] task_answer_data;
   logic core_start, core_done = 0, err_overflow;
   logic [6:0] core_in_count;
   logic [5:0] core_in_rd_addr = 0;
   logic [7:0] core_in_rd_data;
   logic core_out_wr_en = 0;
   logic [3:0] core_out_wr_addr = 0;
   logic [31:0] core_out_wr_data = 0;
   always #5 i_clk = ~i_clk;
   task_slave_shell dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .task_data_request(task_data_request), .task_data_valid(task_data_valid),
      .task_data(task_data), .task_data_last(task_data_last),
      .task_answer_ready(task_answer_ready), .task_answer_data(task_answer_data),
      .task_answer_data_last(task_answer_data_last), .task_manager_ready(task_manager_ready),
      .core_start(core_start), .core_done(core_done), .core_in_count(core_in_count),
      .core_in_rd_addr(core_in_rd_addr), .core_in_rd_data(core_in_rd_data),
      .core_out_wr_en(core_out_wr_en), .core_out_wr_addr(core_out_wr_addr),
      .core_out_wr_data(core_out_wr_data), .err_overflow(err_overflow)
   );
   int vecs = 0, errs = 0, starts = 0;
   bit err_m = 0;
   logic [7:0] tx_q[$];
   logic [31:0] exp_mem [OWN];
   always @(negedge i_clk) if (core_start) starts++;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask
   task automatic check_zero(input string tag);
      chk({tag, "_request"}, task_data_request, 0);
      chk({tag, "_ready"}, task_answer_ready, 0);
      chk({tag, "_data"}, task_answer_data, 0);
      chk({tag, "_last"}, task_answer_data_last, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_rd_data"}, core_in_rd_data, 0);
      chk({tag, "_in_count"}, core_in_count, 0);
      chk({tag, "_err"}, err_overflow, 0);
   endtask
   task automatic send(input bit with_last);
      int n = tx_q.size();
      int exit_i = with_last ? ((n > IB ? IB : n) - 1) : IB - 1;
      int budget = 0;
      while (!task_data_request && budget < 10) begin step(); budget++; end
      chk("request_before_send", task_data_request, 1);
      foreach (tx_q[i]) begin
         if ($urandom_range(3) == 0) begin task_data_valid = 0; step(); end
         task_data_valid = 1;
         task_data = tx_q[i];
         task_data_last = with_last && i == n - 1;
         step();
         if (i > exit_i) err_m = 1;
         chk("request_during_send", task_data_request, i < exit_i);
         chk("core_start_at_exit", core_start, i == exit_i && !LB);
         chk("err_overflow", err_overflow, err_m);
      end
      task_data_valid = 0;
      task_data_last = 0;
   endtask
   task automatic run_core(input bit directed);
      int cnt = tx_q.size() > IB ? IB : tx_q.size();
      int a, budget;
      chk("core_in_count", core_in_count, cnt);
      for (int k = 0; k < 3; k++) begin
         a = (directed && k == 0) ? 3 : $urandom_range(cnt - 1);
         core_in_rd_addr = 6'(a);
         step();
         chk("core_in_rd_data", core_in_rd_data, tx_q[a]);
      end
      if (!LB) begin
         for (int w = 0; w < OWN; w++) begin
            core_out_wr_en = 1;
            core_out_wr_addr = 4'(w);
            core_out_wr_data = directed ? 32'hA0 + 32'(w) : $urandom;
            exp_mem[w] = core_out_wr_data;
            step();
         end
         core_out_wr_en = 0;
         core_done = 1;
         step();
         core_done = 0;
         chk("ready_in_fetch", task_answer_ready, 0);
         step();
         chk("ready_two_after_done", task_answer_ready, 1);
      end else begin
         for (int k = 0; k < OWN; k++) begin
            exp_mem[k] = 0;
            for (int j = 0; j < 4; j++)
               if (4 * k + j < cnt) exp_mem[k] |= 32'(tx_q[4 * k + j]) << (8 * j);
         end
         budget = 0;
         while (!task_answer_ready && budget < OWN + 5) begin step(); budget++; end
      end
   endtask
   task automatic drain(input int hold_idx, input int rst_idx);
      int budget;
      for (int i = 0; i < OWN; i++) begin
         budget = 0;
         while (!task_answer_ready && budget < 8) begin step(); budget++; end
         chk("answer_ready", task_answer_ready, 1);
         chk("answer_data", task_answer_data, exp_mem[i]);
         chk("answer_last", task_answer_data_last, i == OWN - 1);
         if (i == rst_idx) begin
            i_rst = 1;
            step();
            check_zero("mid_reset");
            i_rst = 0;
            err_m = 0;
            step();
            chk("request_after_reset", task_data_request, 1);
            return;
         end
         if (i == hold_idx)
            for (int h = 0; h < 5; h++) begin
               core_done = h == 0;
               step();
               core_done = 0;
               chk("hold_ready", task_answer_ready, 1);
               chk("hold_data", task_answer_data, exp_mem[i]);
               chk("hold_last", task_answer_data_last, i == OWN - 1);
            end
         task_manager_ready = 1;
         step();
         task_manager_ready = 0;
         if (i < OWN - 1) chk("ready_drop_after_accept", task_answer_ready, 0);
      end
      chk("request_low_entering_recv", task_data_request, 0);
      step();
      chk("request_back", task_data_request, 1);
      chk("in_count_cleared", core_in_count, 0);
   endtask
   task automatic run(input bit with_last, input bit directed, input int hold_idx, input int rst_idx);
      int s0 = starts;
      send(with_last);
      run_core(directed);
      chk("core_start_pulses", starts - s0, LB ? 0 : 1);
      drain(hold_idx, rst_idx);
   endtask
   initial begin
      step();
      step();
      check_zero("reset");
      i_rst = 0;
      step();
      chk("request_after_release", task_data_request, 1);
      core_done = 1;
      step();
      core_done = 0;
      chk("done_ignored_ready", task_answer_ready, 0);
      chk("done_ignored_request", task_data_request, 1);
      tx_q = {};
      for (int i = 1; i <= 10; i++) tx_q.push_back(8'(i));
      run(1, 1, 3, -1);
      repeat (3) begin
         tx_q = {};
         repeat ($urandom_range(IB, 1)) tx_q.push_back(8'($urandom));
         run(1, 0, $urandom_range(OWN - 1), -1);
      end
      tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      run(1, 0, -1, -1);
      tx_q = {};
      repeat (IB + 2) tx_q.push_back(8'($urandom));
      run(0, 0, -1, 7);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
